// File: rtl/mips_pkg.sv
// Shared MIPS encodings for the writeback stage: opcode/funct values,
// writeback-source select and fixed register numbers.
package mips_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_COP0    = 6'h10;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;

  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_JALR    = 6'h09;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;
  localparam logic [5:0] FN_MFHI    = 6'h10;
  localparam logic [5:0] FN_MTHI    = 6'h11;
  localparam logic [5:0] FN_MFLO    = 6'h12;
  localparam logic [5:0] FN_MTLO    = 6'h13;
  localparam logic [5:0] FN_MULT    = 6'h18;
  localparam logic [5:0] FN_MULTU   = 6'h19;
  localparam logic [5:0] FN_DIV     = 6'h1A;
  localparam logic [5:0] FN_DIVU    = 6'h1B;

  localparam logic [4:0] RS_MF      = 5'd0;
  localparam logic [4:0] REG_ZERO   = 5'd0;
  localparam logic [4:0] REG_RA     = 5'd31;

  typedef enum logic [2:0] {
    WDSEL_ALU = 3'd0,
    WDSEL_DM  = 3'd1,
    WDSEL_PC8 = 3'd2,
    WDSEL_HI  = 3'd3,
    WDSEL_LO  = 3'd4,
    WDSEL_CP0 = 3'd5
  } wdsel_e;

endpackage

// File: rtl/wb_decode.sv
// W-stage instruction decode: picks the writeback source and destination
// register, folding "no write" and "$0 destination" into a3 = 0.
module wb_decode
  import mips_pkg::*;
(
  input  logic [31:0] ir,
  output wdsel_e      wd_sel,
  output logic [4:0]  a3,
  output logic        we
);

  logic [5:0] op;
  logic [5:0] fn;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;
  logic [4:0] dst;
  logic       wr;
  logic       unused_shamt;

  assign op = ir[31:26];
  assign rs = ir[25:21];
  assign rt = ir[20:16];
  assign rd = ir[15:11];
  assign fn = ir[5:0];
  assign unused_shamt = ^ir[10:6];

  always_comb begin
    wd_sel = WDSEL_ALU;
    dst    = REG_ZERO;
    wr     = 1'b0;
    case (op)
      OP_SPECIAL: begin
        case (fn)
          FN_JR, FN_MULT, FN_MULTU, FN_DIV, FN_DIVU,
          FN_MTHI, FN_MTLO, FN_SYSCALL: wr = 1'b0;
          FN_JALR: begin wr = 1'b1; dst = rd; wd_sel = WDSEL_PC8; end
          FN_MFHI: begin wr = 1'b1; dst = rd; wd_sel = WDSEL_HI;  end
          FN_MFLO: begin wr = 1'b1; dst = rd; wd_sel = WDSEL_LO;  end
          default: begin wr = 1'b1; dst = rd; wd_sel = WDSEL_ALU; end
        endcase
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        wr = 1'b1; dst = rt; wd_sel = WDSEL_DM;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        wr = 1'b1; dst = rt; wd_sel = WDSEL_ALU;
      end
      OP_JAL: begin
        wr = 1'b1; dst = REG_RA; wd_sel = WDSEL_PC8;
      end
      // Only mfc0 writes a GPR; mtc0 and eret share the opcode.
      OP_COP0: begin
        if (rs == RS_MF) begin
          wr = 1'b1; dst = rt; wd_sel = WDSEL_CP0;
        end
      end
      default: wr = 1'b0;
    endcase
  end

  assign a3 = (wr && dst != REG_ZERO) ? dst : REG_ZERO;
  assign we = (a3 != REG_ZERO);

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: selects WD, owns the 32x32 GRF with write-through read
// ports, exports the W write triple and counts retired instructions.
module wb_regfile
  import mips_pkg::*;
#(
  parameter int TRACE_EN = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IR_W,
  input  logic [31:0] pc4_W,
  input  logic [31:0] pc8_W,
  input  logic [31:0] ALUResult_W,
  input  logic [31:0] DM_RD_W,
  input  logic [31:0] hi_W,
  input  logic [31:0] lo_W,
  input  logic [31:0] CP0_data_W,
  input  logic [4:0]  A1_D,
  input  logic [4:0]  A2_D,
  output logic [31:0] RD1_D,
  output logic [31:0] RD2_D,
  output logic [4:0]  A3_W,
  output logic [31:0] WD_W,
  output logic        WE_W,
  output logic [31:0] retired
);

  wdsel_e      wd_sel;
  logic [31:0] grf [32];
  logic [31:0] pc_w;

  assign pc_w = pc4_W - 32'd4;

  wb_decode u_decode (
    .ir     (IR_W),
    .wd_sel (wd_sel),
    .a3     (A3_W),
    .we     (WE_W)
  );

  always_comb begin
    WD_W = ALUResult_W;
    case (wd_sel)
      WDSEL_ALU: WD_W = ALUResult_W;
      WDSEL_DM:  WD_W = DM_RD_W;
      WDSEL_PC8: WD_W = pc8_W;
      WDSEL_HI:  WD_W = hi_W;
      WDSEL_LO:  WD_W = lo_W;
      WDSEL_CP0: WD_W = CP0_data_W;
      default:   WD_W = ALUResult_W;
    endcase
  end

  // Same-cycle write-through lets D read the value W is about to commit.
  assign RD1_D = (A1_D == REG_ZERO)          ? 32'd0 :
                 (WE_W && A3_W == A1_D)      ? WD_W  : grf[A1_D];
  assign RD2_D = (A2_D == REG_ZERO)          ? 32'd0 :
                 (WE_W && A3_W == A2_D)      ? WD_W  : grf[A2_D];

  // ---- W commit boundary: GRF write, retire count, trace ----
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) grf[i] <= 32'd0;
      retired <= 32'd0;
    end else begin
      if (WE_W) begin
        grf[A3_W] <= WD_W;
        if (TRACE_EN != 0) $display("@%h: $%d <= %h", pc_w, A3_W, WD_W);
      end
      if (IR_W != 32'd0) retired <= retired + 32'd1;
    end
  end

endmodule
